// File: rtl/hilo_unit.sv
// HI/LO sequencing stage around the iterative multiplier: launches Mult with
// sign-stripped operands, waits for its result, and commits the fixed-up product.
module hilo_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        mult_valid_in,
    output logic [31:0] mult_src_a,
    output logic [31:0] mult_src_b,
    input  logic        mult_valid_out,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COMMIT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q;
    logic [31:0]        src_a_q, src_b_q;
    logic [63:0]        raw_q;
    logic [31:0]        hi_q, lo_q;
    logic               done_q, timeout_q;

    logic               accept;
    logic               is_mult;
    logic               signed_op;
    logic               wait_hit;
    logic               wait_expire;

    // Unsigned magnitude of a signed operand; 0x80000000 stays 0x80000000.
    function automatic logic [31:0] magnitude32(input logic en, input logic [31:0] v);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] negate64(input logic en, input logic [63:0] v);
        return en ? (~v + 64'd1) : v;
    endfunction

    assign accept      = op_valid && (state_q == IDLE);
    assign is_mult     = (op == OP_MULT) || (op == OP_MULTU);
    assign signed_op   = (op == OP_MULT);
    assign wait_hit    = (state_q == WAIT) && mult_valid_out;
    assign wait_expire = (state_q == WAIT) && !mult_valid_out && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (accept && is_mult) state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mult_valid_out)   state_d = COMMIT;
                else if (wait_expire) state_d = IDLE;
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            raw_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (state_q == COMMIT);
            if (accept && is_mult) begin
                neg_q   <= signed_op && (rs_val[31] ^ rt_val[31]);
                src_a_q <= magnitude32(signed_op, rs_val);
                src_b_q <= magnitude32(signed_op, rt_val);
            end
            if (accept && (op == OP_MTHI)) hi_q <= rs_val;
            if (accept && (op == OP_MTLO)) lo_q <= rs_val;
            if (wait_hit) raw_q <= {mult_hi, mult_lo};
            if (wait_expire) timeout_q <= 1'b1;
            if (state_q == COMMIT) {hi_q, lo_q} <= negate64(neg_q, raw_q);
        end
    end

    assign busy          = (state_q != IDLE);
    assign op_ready      = !busy;
    assign mult_valid_in = (state_q == LAUNCH);
    assign mult_src_a    = src_a_q;
    assign mult_src_b    = src_b_q;
    assign hi_out        = hi_q;
    assign lo_out        = lo_q;
    assign done          = done_q;
    assign timeout       = timeout_q;

endmodule
